// File: rtl/ldlt_decomp.sv
// ============================================================================
// Module      : ldlt_decomp
// Description : Fixed-point LDL^T factorisation of a symmetric 6x6 matrix,
//               built on one shared 2-stage multiplier and 3-stage divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ldlt_decomp #(
  parameter int MATRIX_BW = 32,
  parameter int MUL       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [MATRIX_BW-1:0] i_Mat_00,
  input  logic [MATRIX_BW-1:0] i_Mat_10,
  input  logic [MATRIX_BW-1:0] i_Mat_20,
  input  logic [MATRIX_BW-1:0] i_Mat_30,
  input  logic [MATRIX_BW-1:0] i_Mat_40,
  input  logic [MATRIX_BW-1:0] i_Mat_50,
  input  logic [MATRIX_BW-1:0] i_Mat_11,
  input  logic [MATRIX_BW-1:0] i_Mat_21,
  input  logic [MATRIX_BW-1:0] i_Mat_31,
  input  logic [MATRIX_BW-1:0] i_Mat_41,
  input  logic [MATRIX_BW-1:0] i_Mat_51,
  input  logic [MATRIX_BW-1:0] i_Mat_22,
  input  logic [MATRIX_BW-1:0] i_Mat_32,
  input  logic [MATRIX_BW-1:0] i_Mat_42,
  input  logic [MATRIX_BW-1:0] i_Mat_52,
  input  logic [MATRIX_BW-1:0] i_Mat_33,
  input  logic [MATRIX_BW-1:0] i_Mat_43,
  input  logic [MATRIX_BW-1:0] i_Mat_53,
  input  logic [MATRIX_BW-1:0] i_Mat_44,
  input  logic [MATRIX_BW-1:0] i_Mat_54,
  input  logic [MATRIX_BW-1:0] i_Mat_55,
  output logic                 o_done,
  output logic                 o_div_zero,
  output logic [MATRIX_BW-1:0] o_Mat_00,
  output logic [MATRIX_BW-1:0] o_Mat_11,
  output logic [MATRIX_BW-1:0] o_Mat_22,
  output logic [MATRIX_BW-1:0] o_Mat_33,
  output logic [MATRIX_BW-1:0] o_Mat_44,
  output logic [MATRIX_BW-1:0] o_Mat_55,
  output logic [MATRIX_BW-1:0] o_Mat_10,
  output logic [MATRIX_BW-1:0] o_Mat_20,
  output logic [MATRIX_BW-1:0] o_Mat_30,
  output logic [MATRIX_BW-1:0] o_Mat_40,
  output logic [MATRIX_BW-1:0] o_Mat_50,
  output logic [MATRIX_BW-1:0] o_Mat_21,
  output logic [MATRIX_BW-1:0] o_Mat_31,
  output logic [MATRIX_BW-1:0] o_Mat_41,
  output logic [MATRIX_BW-1:0] o_Mat_51,
  output logic [MATRIX_BW-1:0] o_Mat_32,
  output logic [MATRIX_BW-1:0] o_Mat_42,
  output logic [MATRIX_BW-1:0] o_Mat_52,
  output logic [MATRIX_BW-1:0] o_Mat_43,
  output logic [MATRIX_BW-1:0] o_Mat_53,
  output logic [MATRIX_BW-1:0] o_Mat_54
);

  localparam int N      = 6;
  localparam int PW     = 2 * MATRIX_BW;
  localparam int QW     = MATRIX_BW + MUL;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] C_BUSY_LAST = 8'd164;
  localparam logic [2:0]       C_LAST_IDX  = 3'd5;
  localparam logic signed [PW-1:0] C_RND = {{(PW-MUL){1'b0}}, {MUL{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_BUSY   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [MATRIX_BW-1:0] r_u  [N][N];
  logic signed [MATRIX_BW-1:0] r_l  [N][N];
  logic        [MATRIX_BW-1:0] r_od [N];
  logic        [MATRIX_BW-1:0] r_ol [N][N];

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_j;
  logic [2:0]       r_i;
  logic [2:0]       r_k;
  logic [1:0]       r_sub;
  logic             r_div_ph;
  logic             r_done;
  logic             r_dz;

  logic signed [MATRIX_BW-1:0] w_d;
  logic signed [MATRIX_BW-1:0] w_mul_a;
  logic signed [MATRIX_BW-1:0] w_mul_b;
  logic signed [PW-1:0]        w_prod;
  logic signed [PW-1:0]        w_mul_adj;
  logic                        w_slot_end;

  logic signed [PW-1:0]        r_mul_p;
  logic signed [MATRIX_BW-1:0] r_mul_s;
  logic signed [QW-1:0]        r_dv_num;
  logic signed [QW-1:0]        r_dv_den;
  logic signed [MATRIX_BW-1:0] r_dv_q;
  logic signed [MATRIX_BW-1:0] r_dv_q2;

  assign w_d     = r_u[r_j][r_j];
  assign w_mul_a = r_u[r_i][r_k];
  assign w_mul_b = r_l[r_j][r_k];
  assign w_prod  = $signed({{MATRIX_BW{w_mul_a[MATRIX_BW-1]}}, w_mul_a})
                 * $signed({{MATRIX_BW{w_mul_b[MATRIX_BW-1]}}, w_mul_b});
  // Bias negative products so the arithmetic shift truncates toward zero.
  assign w_mul_adj  = r_mul_p + (r_mul_p[PW-1] ? C_RND : '0);
  assign w_slot_end = r_div_ph ? (r_sub == 2'd3) : (r_sub == 2'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_BUSY;
      S_BUSY:   if (r_cnt == C_BUSY_LAST) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Shared arithmetic pipelines run every cycle; the sequencer picks results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mul_p  <= '0;
      r_mul_s  <= '0;
      r_dv_num <= '0;
      r_dv_den <= '0;
      r_dv_q   <= '0;
      r_dv_q2  <= '0;
    end else begin
      r_mul_p  <= w_prod;
      r_mul_s  <= MATRIX_BW'(w_mul_adj >>> MUL);
      r_dv_num <= {r_u[r_i][r_j], {MUL{1'b0}}};
      r_dv_den <= (w_d == '0) ? QW'(1) : {{MUL{w_d[MATRIX_BW-1]}}, w_d};
      r_dv_q   <= MATRIX_BW'(r_dv_num / r_dv_den);
      r_dv_q2  <= r_dv_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_u[r][c]  <= '0;
          r_l[r][c]  <= '0;
          r_ol[r][c] <= '0;
        end
        r_od[r] <= '0;
      end
      r_cnt    <= '0;
      r_j      <= '0;
      r_i      <= '0;
      r_k      <= '0;
      r_sub    <= '0;
      r_div_ph <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_u[0][0] <= i_Mat_00;
          r_u[1][0] <= i_Mat_10;
          r_u[2][0] <= i_Mat_20;
          r_u[3][0] <= i_Mat_30;
          r_u[4][0] <= i_Mat_40;
          r_u[5][0] <= i_Mat_50;
          r_u[1][1] <= i_Mat_11;
          r_u[2][1] <= i_Mat_21;
          r_u[3][1] <= i_Mat_31;
          r_u[4][1] <= i_Mat_41;
          r_u[5][1] <= i_Mat_51;
          r_u[2][2] <= i_Mat_22;
          r_u[3][2] <= i_Mat_32;
          r_u[4][2] <= i_Mat_42;
          r_u[5][2] <= i_Mat_52;
          r_u[3][3] <= i_Mat_33;
          r_u[4][3] <= i_Mat_43;
          r_u[5][3] <= i_Mat_53;
          r_u[4][4] <= i_Mat_44;
          r_u[5][4] <= i_Mat_54;
          r_u[5][5] <= i_Mat_55;
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              r_l[r][c] <= '0;
            end
          end
          r_dz     <= 1'b0;
          r_cnt    <= '0;
          r_sub    <= '0;
          // Column 0 has no MAC work, so the schedule opens with its divides.
          r_j      <= 3'd0;
          r_i      <= 3'd1;
          r_k      <= 3'd0;
          r_div_ph <= 1'b1;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          r_sub <= w_slot_end ? 2'd0 : r_sub + 2'd1;
          if (!r_div_ph && r_sub == 2'd2) begin
            r_u[r_i][r_j] <= r_u[r_i][r_j] - r_mul_s;
          end
          if (r_div_ph && r_sub == 2'd3) begin
            if (w_d == '0) begin
              r_l[r_i][r_j] <= '0;
              r_dz          <= 1'b1;
            end else begin
              r_l[r_i][r_j] <= r_dv_q2;
            end
          end
          if (w_slot_end) begin
            if (!r_div_ph) begin
              if (r_k != r_j - 3'd1) begin
                r_k <= r_k + 3'd1;
              end else begin
                r_k <= 3'd0;
                if (r_i != C_LAST_IDX) begin
                  r_i <= r_i + 3'd1;
                end else if (r_j != C_LAST_IDX) begin
                  r_div_ph <= 1'b1;
                  r_i      <= r_j + 3'd1;
                end
              end
            end else begin
              if (r_i != C_LAST_IDX) begin
                r_i <= r_i + 3'd1;
              end else begin
                r_j      <= r_j + 3'd1;
                r_i      <= r_j + 3'd1;
                r_k      <= 3'd0;
                r_div_ph <= 1'b0;
              end
            end
          end
        end
        S_FINISH: begin
          for (int r = 0; r < N; r++) begin
            r_od[r] <= r_u[r][r];
            for (int c = 0; c < N; c++) begin
              r_ol[r][c] <= r_l[r][c];
            end
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_done     = r_done;
  assign o_div_zero = r_dz;

  assign o_Mat_00 = r_od[0];
  assign o_Mat_11 = r_od[1];
  assign o_Mat_22 = r_od[2];
  assign o_Mat_33 = r_od[3];
  assign o_Mat_44 = r_od[4];
  assign o_Mat_55 = r_od[5];
  assign o_Mat_10 = r_ol[1][0];
  assign o_Mat_20 = r_ol[2][0];
  assign o_Mat_30 = r_ol[3][0];
  assign o_Mat_40 = r_ol[4][0];
  assign o_Mat_50 = r_ol[5][0];
  assign o_Mat_21 = r_ol[2][1];
  assign o_Mat_31 = r_ol[3][1];
  assign o_Mat_41 = r_ol[4][1];
  assign o_Mat_51 = r_ol[5][1];
  assign o_Mat_32 = r_ol[3][2];
  assign o_Mat_42 = r_ol[4][2];
  assign o_Mat_52 = r_ol[5][2];
  assign o_Mat_43 = r_ol[4][3];
  assign o_Mat_53 = r_ol[5][3];
  assign o_Mat_54 = r_ol[5][4];

endmodule

`default_nettype wire

// File: tb/tb_ldlt_decomp.sv
// ============================================================================
// Module      : tb_ldlt_decomp
// Description : Directed-vector bench for ldlt_decomp (Q16.16, 32-bit words).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ldlt_decomp;

  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  typedef struct packed {
    logic [20:0][W-1:0] a;
    logic [5:0][W-1:0]  d;
    logic [14:0][W-1:0] l;
    logic               dz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in  [21];
  logic [W-1:0] d_out [6];
  logic [W-1:0] l_out [15];
  logic         done;
  logic         dz;

  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ldlt_decomp #(.MATRIX_BW(W), .MUL(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_Mat_00(a_in[0]),  .i_Mat_10(a_in[1]),  .i_Mat_20(a_in[2]),
    .i_Mat_30(a_in[3]),  .i_Mat_40(a_in[4]),  .i_Mat_50(a_in[5]),
    .i_Mat_11(a_in[6]),  .i_Mat_21(a_in[7]),  .i_Mat_31(a_in[8]),
    .i_Mat_41(a_in[9]),  .i_Mat_51(a_in[10]), .i_Mat_22(a_in[11]),
    .i_Mat_32(a_in[12]), .i_Mat_42(a_in[13]), .i_Mat_52(a_in[14]),
    .i_Mat_33(a_in[15]), .i_Mat_43(a_in[16]), .i_Mat_53(a_in[17]),
    .i_Mat_44(a_in[18]), .i_Mat_54(a_in[19]), .i_Mat_55(a_in[20]),
    .o_done(done), .o_div_zero(dz),
    .o_Mat_00(d_out[0]), .o_Mat_11(d_out[1]), .o_Mat_22(d_out[2]),
    .o_Mat_33(d_out[3]), .o_Mat_44(d_out[4]), .o_Mat_55(d_out[5]),
    .o_Mat_10(l_out[0]),  .o_Mat_20(l_out[1]),  .o_Mat_30(l_out[2]),
    .o_Mat_40(l_out[3]),  .o_Mat_50(l_out[4]),  .o_Mat_21(l_out[5]),
    .o_Mat_31(l_out[6]),  .o_Mat_41(l_out[7]),  .o_Mat_51(l_out[8]),
    .o_Mat_32(l_out[9]),  .o_Mat_42(l_out[10]), .o_Mat_52(l_out[11]),
    .o_Mat_43(l_out[12]), .o_Mat_53(l_out[13]), .o_Mat_54(l_out[14])
  );

  function automatic int ai(input int r, input int c);
    int off [6];
    off = '{0, 6, 11, 15, 18, 20};
    return off[c] + r - c;
  endfunction

  function automatic int li(input int r, input int c);
    int off [5];
    off = '{0, 5, 9, 12, 14};
    return off[c] + r - c - 1;
  endfunction

  function automatic vec_t ident();
    vec_t v;
    v = '0;
    for (int c = 0; c < 6; c++) begin
      v.a[ai(c, c)] = ONE;
      v.d[c]        = ONE;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id, input int pulse_at);
    int lat;
    bit got;
    for (int i = 0; i < 21; i++) a_in[i] = v.a[i];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == pulse_at);
      if (lat == 1) chk($sformatf("v%0d dz_clear_at_load", id), {31'b0, dz}, 32'd0);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk($sformatf("v%0d latency", id), lat, 32'd167);
    if (got) begin
      chk($sformatf("v%0d div_zero", id), {31'b0, dz}, {31'b0, v.dz});
      for (int c = 0; c < 6; c++) chk($sformatf("v%0d D%0d", id, c), d_out[c], v.d[c]);
      for (int c = 0; c < 5; c++)
        for (int r = c + 1; r < 6; r++)
          chk($sformatf("v%0d L%0d%0d", id, r, c), l_out[li(r, c)], v.l[li(r, c)]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done_pulse", id), {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 21; i++) a_in[i] = '0;

    // Hand-computed vectors (Q16.16)
    vecs[0] = ident();

    vecs[1] = ident();
    vecs[1].a[ai(0, 0)] = 32'h0004_0000;
    vecs[1].a[ai(1, 0)] = 32'h0002_0000;
    vecs[1].a[ai(1, 1)] = 32'h0005_0000;
    vecs[1].d[0]        = 32'h0004_0000;
    vecs[1].d[1]        = 32'h0004_0000;
    vecs[1].l[li(1, 0)] = 32'h0000_8000;

    vecs[2] = ident();
    vecs[2].a[ai(0, 0)] = 32'h0;
    vecs[2].a[ai(1, 0)] = ONE;
    vecs[2].d[0]        = 32'h0;
    vecs[2].dz          = 1'b1;

    vecs[3] = ident();
    vecs[3].a[ai(0, 0)] = 32'hFFFF_0000;
    vecs[3].a[ai(1, 0)] = 32'h0000_0001;
    vecs[3].d[0]        = 32'hFFFF_0000;
    vecs[3].l[li(1, 0)] = 32'hFFFF_FFFF;

    vecs[4] = ident();
    vecs[4].a[ai(0, 0)] = 32'h0002_0000;
    vecs[4].a[ai(1, 0)] = 32'hFFFD_0000;
    vecs[4].a[ai(1, 1)] = 32'h0005_0000;
    vecs[4].a[ai(2, 1)] = 32'h0000_4000;
    vecs[4].d[0]        = 32'h0002_0000;
    vecs[4].d[1]        = 32'h0000_8000;
    vecs[4].d[2]        = 32'h0000_E000;
    vecs[4].l[li(1, 0)] = 32'hFFFE_8000;
    vecs[4].l[li(2, 1)] = 32'h0000_8000;

    vecs[5] = ident();
    vecs[5].a[ai(0, 0)] = 32'h0004_0000;
    vecs[5].a[ai(5, 0)] = 32'hFFFF_0000;
    vecs[5].a[ai(5, 4)] = 32'h0000_8000;
    vecs[5].a[ai(5, 5)] = 32'h0003_0000;
    vecs[5].d[0]        = 32'h0004_0000;
    vecs[5].d[5]        = 32'h0002_8000;
    vecs[5].l[li(5, 0)] = 32'hFFFF_C000;
    vecs[5].l[li(5, 4)] = 32'h0000_8000;

    #12;
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset div_zero", {31'b0, dz}, 32'd0);
    chk("reset D0", d_out[0], 32'd0);
    chk("reset L54", l_out[14], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v, 0);

    // Start pulse in the middle of a run must be ignored.
    run_vec(vecs[1], 11, 50);

    // Reset in the middle of a run aborts and clears the outputs.
    for (int i = 0; i < 21; i++) a_in[i] = vecs[0].a[i];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst D0", d_out[0], 32'd0);
    chk("midrst L10", l_out[0], 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 180; c++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("midrst no_done_after_abort", seen, 32'd0);
    run_vec(vecs[0], 20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
